// File: rtl/a2d_multi_intf.sv
// Multi-channel A2D sequencer driving an external SPI monarch.
// Define A2D_AVG_EN to average each new sample with the stored result.
module a2d_multi_intf #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 12,
  parameter logic [3*NUM_CH-1:0] CH_ADDR = {3'd6, 3'd5, 3'd4, 3'd0}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     nxt,
  input  logic                     auto_en,
  input  logic [NUM_CH-1:0]        chan_en,
  output logic                     wrt,
  output logic [15:0]              cmd,
  input  logic                     done,
  input  logic [15:0]              rd_data,
  output logic [NUM_CH*DATA_W-1:0] results,
  output logic [NUM_CH-1:0]        upd,
  input  logic [NUM_CH-1:0]        upd_clr,
  output logic                     conv_done,
  output logic [2:0]               conv_ch,
  output logic                     busy
);

  typedef enum logic [2:0] {IDLE, CMD, STALL, READ, UPDT} state_t;

  state_t            state, state_nxt;
  logic [2:0]        ptr, cur_ch, cand, sel, ptr_nxt;
  logic              start, wrt_c;
  logic [DATA_W-1:0] sample, new_res;
  logic [DATA_W-1:0] res [NUM_CH];
  logic [NUM_CH-1:0] upd_set;
  logic              unused_rd;

  assign unused_rd = ^rd_data;

  // Lowest enabled index wins, then any enabled index at/after ptr overrides.
  always_comb begin
    cand = ptr;
    for (int i = NUM_CH-1; i >= 0; i--)
      if (chan_en[i]) cand = 3'(i);
    for (int i = NUM_CH-1; i >= 0; i--)
      if (chan_en[i] && 3'(i) >= ptr) cand = 3'(i);
  end

  assign start   = (nxt | auto_en) & (|chan_en);
  assign sel     = (state == IDLE) ? cand : cur_ch;
  assign cmd     = {2'b00, CH_ADDR[3*sel +: 3], 11'h000};
  assign busy    = (state != IDLE);
  assign wrt     = wrt_c & ~rst;
  assign ptr_nxt = (cur_ch == 3'(NUM_CH-1)) ? 3'd0 : cur_ch + 3'd1;

  always_comb begin
    state_nxt = state;
    wrt_c     = 1'b0;
    unique case (state)
      IDLE:
        if (start) begin
          wrt_c     = 1'b1;
          state_nxt = CMD;
        end
      CMD:     if (done) state_nxt = STALL;
      STALL: begin
        wrt_c     = 1'b1;
        state_nxt = READ;
      end
      READ:    if (done) state_nxt = UPDT;
      UPDT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    upd_set = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (state == UPDT && cur_ch == 3'(i)) upd_set[i] = 1'b1;
  end

`ifdef A2D_AVG_EN
  logic [NUM_CH-1:0] seen;
  logic [DATA_W-1:0] cur_res;
  logic              cur_seen;
  logic [DATA_W:0]   sum;

  always_comb begin
    cur_res  = '0;
    cur_seen = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (cur_ch == 3'(i)) begin
        cur_res  = res[i];
        cur_seen = seen[i];
      end
  end

  assign sum     = {1'b0, cur_res} + {1'b0, sample};
  assign new_res = cur_seen ? DATA_W'(sum >> 1) : sample;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) seen <= '0;
    else     seen <= seen | upd_set;
  end
`else
  assign new_res = sample;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cur_ch    <= '0;
      sample    <= '0;
      upd       <= '0;
      conv_done <= 1'b0;
      conv_ch   <= '0;
    end else begin
      state     <= state_nxt;
      conv_done <= (state == UPDT);
      upd       <= (upd & ~upd_clr) | upd_set;
      if (state == IDLE && start) cur_ch <= cand;
      if (state == READ && done) sample <= rd_data[DATA_W-1:0];
      if (state == UPDT) begin
        ptr     <= ptr_nxt;
        conv_ch <= cur_ch;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) res[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (upd_set[i]) res[i] <= new_res;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign results[g*DATA_W +: DATA_W] = res[g];
  end

endmodule

// File: tb/tb_a2d_multi_intf.sv
// Directed bench for a2d_multi_intf with a fixed-latency SPI responder.
// Responder returns data_tab[addr] two cycles after each wrt.
module tb_a2d_multi_intf;

  logic        clk = 1'b0;
  logic        rst, nxt, auto_en;
  logic [3:0]  chan_en, upd_clr, upd;
  logic        wrt;
  logic        done = 1'b0;
  logic [15:0] cmd;
  logic [15:0] rd_data = 16'h0;
  logic [47:0] results;
  logic        conv_done, busy;
  logic [2:0]  conv_ch;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] data_tab [8];
  int          wrt_cnt = 0;
  int          pend = 0;
  int          txn = 0;
  bit          mute = 1'b0;
  logic [2:0]  cur_addr = 3'd0;
  logic [2:0]  addr_q [$];

  always #5 clk = ~clk;

  a2d_multi_intf dut (
    .clk(clk), .rst(rst), .nxt(nxt), .auto_en(auto_en),
    .chan_en(chan_en), .wrt(wrt), .cmd(cmd), .done(done),
    .rd_data(rd_data), .results(results), .upd(upd),
    .upd_clr(upd_clr), .conv_done(conv_done),
    .conv_ch(conv_ch), .busy(busy)
  );

  always @(negedge clk) begin
    done = 1'b0;
    if (rst) begin
      pend = 0;
      txn  = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0 && !(mute && (txn % 2 == 0))) begin
          done    = 1'b1;
          rd_data = data_tab[cur_addr];
        end
      end
      if (wrt) begin
        wrt_cnt++;
        txn++;
        addr_q.push_back(cmd[13:11]);
        cur_addr = cmd[13:11];
        pend = 2;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_conv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (conv_done) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_nxt();
    tick();
    nxt = 1'b1;
    tick();
    nxt = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; nxt = 1'b0; auto_en = 1'b0;
    chan_en = 4'h0; upd_clr = 4'h0;
    tick(); tick();
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_busy got %b want 0", busy);
    end
    n_cmp++;
    if (wrt !== 1'b0) begin
      n_bad++; $display("FAIL reset_wrt got %b want 0", wrt);
    end
    n_cmp++;
    if (results !== 48'h0) begin
      n_bad++; $display("FAIL reset_results got %h want 0", results);
    end
    n_cmp++;
    if (upd !== 4'h0) begin
      n_bad++; $display("FAIL reset_upd got %h want 0", upd);
    end
    n_cmp++;
    if (conv_done !== 1'b0 || conv_ch !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_conv got %b/%0d want 0/0", conv_done, conv_ch);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [2:0] exp_addr [4];
    int base, w0;
    bit ok;
    exp_addr = '{3'd0, 3'd4, 3'd5, 3'd6};
    data_tab[0] = 16'h0ABC; data_tab[4] = 16'h0123;
    data_tab[5] = 16'h0456; data_tab[6] = 16'h0789;
    chan_en = 4'hF;
    base = addr_q.size();
    for (int i = 0; i < 4; i++) begin
      w0 = wrt_cnt;
      pulse_nxt();
      wait_conv(ok);
      n_cmp++;
      if (!ok) begin
        n_bad++; $display("FAIL seq_timeout ch %0d got none want conv_done", i);
      end else if (conv_ch !== 3'(i)) begin
        n_bad++; $display("FAIL seq_conv_ch got %0d want %0d", conv_ch, i);
      end
      n_cmp++;
      if (wrt_cnt - w0 != 2) begin
        n_bad++; $display("FAIL seq_wrt_cnt got %0d want 2", wrt_cnt - w0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (addr_q.size() < base + 2*i + 2) begin
        n_bad++; $display("FAIL seq_addr%0d got missing want %0d", i, exp_addr[i]);
      end else if (addr_q[base+2*i] !== exp_addr[i] ||
                   addr_q[base+2*i+1] !== exp_addr[i]) begin
        n_bad++;
        $display("FAIL seq_addr%0d got %0d/%0d want %0d", i,
                 addr_q[base+2*i], addr_q[base+2*i+1], exp_addr[i]);
      end
    end
    n_cmp++;
    if (results !== 48'h789_456_123_ABC) begin
      n_bad++; $display("FAIL seq_results got %h want 789456123abc", results);
    end
    n_cmp++;
    if (upd !== 4'hF) begin
      n_bad++; $display("FAIL seq_upd got %h want f", upd);
    end
    tick(); upd_clr = 4'b0101;
    tick(); upd_clr = 4'h0;
    @(negedge clk);
    n_cmp++;
    if (upd !== 4'b1010) begin
      n_bad++; $display("FAIL upd_clr got %b want 1010", upd);
    end
  endtask

  task automatic test_mask_auto();
    logic [2:0] exp_ch [3];
    logic [2:0] exp_ad [3];
    int base;
    bit ok, idle;
    exp_ch = '{3'd1, 3'd3, 3'd1};
    exp_ad = '{3'd4, 3'd6, 3'd4};
    do_reset();
    chan_en = 4'b1010;
    data_tab[4] = 16'h0111; data_tab[6] = 16'h0333;
    base = addr_q.size();
    tick(); auto_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_conv(ok);
      n_cmp++;
      if (!ok) begin
        n_bad++; $display("FAIL auto_timeout %0d got none want conv_done", i);
      end else if (conv_ch !== exp_ch[i]) begin
        n_bad++; $display("FAIL auto_ch%0d got %0d want %0d", i, conv_ch, exp_ch[i]);
      end
    end
    tick(); auto_en = 1'b0;
    idle = 1'b0;
    for (int i = 0; i < 60 && !idle; i++) begin
      @(negedge clk);
      if (!busy && !conv_done) idle = 1'b1;
    end
    n_cmp++;
    if (!idle) begin
      n_bad++; $display("FAIL auto_stop got busy want idle");
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (addr_q.size() <= base + 2*i) begin
        n_bad++; $display("FAIL auto_addr%0d got missing want %0d", i, exp_ad[i]);
      end else if (addr_q[base+2*i] !== exp_ad[i]) begin
        n_bad++;
        $display("FAIL auto_addr%0d got %0d want %0d", i, addr_q[base+2*i], exp_ad[i]);
      end
    end
    n_cmp++;
    if (results !== 48'h333_000_111_000) begin
      n_bad++; $display("FAIL auto_results got %h want 333000111000", results);
    end
  endtask

  task automatic test_zero_mask();
    int w0;
    bit saw_busy;
    chan_en = 4'h0;
    w0 = wrt_cnt;
    saw_busy = 1'b0;
    tick(); nxt = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
      if (i == 1) nxt = 1'b0;
    end
    n_cmp++;
    if (wrt_cnt != w0) begin
      n_bad++; $display("FAIL zero_mask_wrt got %0d want 0", wrt_cnt - w0);
    end
    n_cmp++;
    if (saw_busy) begin
      n_bad++; $display("FAIL zero_mask_busy got 1 want 0");
    end
  endtask

  task automatic test_nxt_busy();
    logic [6:0] pat;
    int w0;
    bit ok;
    pat = 7'b0110111;
    chan_en = 4'hF;
    w0 = wrt_cnt;
    for (int k = 0; k < 7; k++) begin
      tick();
      nxt = pat[k];
    end
    wait_conv(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL busy_timeout got none want conv_done");
    end
    repeat (6) @(negedge clk);
    n_cmp++;
    if (wrt_cnt - w0 != 2 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_nxt got wrt %0d busy %b want 2/0", wrt_cnt - w0, busy);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    bit ok;
    do_reset();
    chan_en = 4'hF;
    data_tab[0] = 16'h05A5;
    mute = 1'b1;
    pulse_nxt();
    repeat (8) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL mid_stuck got busy %b want 1", busy);
    end
    tick(); rst = 1'b1; nxt = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (wrt !== 1'b0 || busy !== 1'b0 || results !== 48'h0) begin
      n_bad++;
      $display("FAIL mid_reset got wrt %b busy %b res %h want 0/0/0", wrt, busy, results);
    end
    tick(); rst = 1'b0; nxt = 1'b0; mute = 1'b0;
    base = addr_q.size();
    pulse_nxt();
    wait_conv(ok);
    n_cmp++;
    if (!ok || conv_ch !== 3'd0 || addr_q.size() <= base || addr_q[base] !== 3'd0) begin
      n_bad++; $display("FAIL mid_restart got ok %b ch %0d want ch 0", ok, conv_ch);
    end
    n_cmp++;
    if (results[11:0] !== 12'h5A5) begin
      n_bad++; $display("FAIL mid_result got %h want 5a5", results[11:0]);
    end
  endtask

  task automatic test_avg_upd();
    logic [11:0] exp2, exp3;
    bit ok;
`ifdef A2D_AVG_EN
    exp2 = 12'h200;
    exp3 = 12'h8FF;
`else
    exp2 = 12'h300;
    exp3 = 12'hFFF;
`endif
    do_reset();
    chan_en = 4'b0001;
    data_tab[0] = 16'h0100;
    pulse_nxt();
    wait_conv(ok);
    n_cmp++;
    if (!ok || results[11:0] !== 12'h100 || upd[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL avg_first got %h upd %b want 100/1", results[11:0], upd[0]);
    end
    data_tab[0] = 16'h0300;
    tick(); nxt = 1'b1; upd_clr = 4'h1;
    repeat (7) begin
      tick();
      nxt = 1'b0;
    end
    upd_clr = 4'h0;
    @(negedge clk);
    n_cmp++;
    if (conv_done !== 1'b1) begin
      n_bad++; $display("FAIL avg_latency got conv_done %b want 1", conv_done);
    end
    n_cmp++;
    if (upd[0] !== 1'b1) begin
      n_bad++; $display("FAIL upd_set_wins got %b want 1", upd[0]);
    end
    n_cmp++;
    if (results[11:0] !== exp2) begin
      n_bad++; $display("FAIL avg_second got %h want %h", results[11:0], exp2);
    end
    data_tab[0] = 16'hFFFF;
    pulse_nxt();
    wait_conv(ok);
    n_cmp++;
    if (!ok || results[11:0] !== exp3) begin
      n_bad++; $display("FAIL avg_third got %h want %h", results[11:0], exp3);
    end
    tick(); upd_clr = 4'hF;
    tick(); upd_clr = 4'h0;
    @(negedge clk);
    n_cmp++;
    if (upd !== 4'h0) begin
      n_bad++; $display("FAIL upd_clr_all got %h want 0", upd);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) data_tab[i] = 16'h0;
    test_reset();
    test_sequential();
    test_mask_auto();
    test_zero_mask();
    test_nxt_busy();
    test_reset_mid();
    test_avg_upd();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
